// File: rtl/flit_packer_if.sv
// Handshake bundle between the flit compressor, the packer and the link.
// Master drives flits in and consumes link words; slave is the packer.
interface flit_packer_if #(
   parameter int WORD_W = 128,
   parameter int CNT_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] data_in;
   logic [CNT_W-1:0]  count_in;
   logic              last_in;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;
   logic [CNT_W-1:0]  out_bits;
   logic              out_last;
   logic              err_out;

   modport master (
      output in_valid, data_in, count_in, last_in, out_ready,
      input  in_ready, out_valid, out_data, out_bits, out_last, err_out
   );

   modport slave (
      input  in_valid, data_in, count_in, last_in, out_ready,
      output in_ready, out_valid, out_data, out_bits, out_last, err_out
   );
endinterface

// File: rtl/flit_packer.sv
// Packs variable-length flits LSB-first into 128-bit link words; a completed word is valid one cycle later.
// Backpressure: in_ready comes from registered fill/state only; output words hold stable until out_ready.
module flit_packer #(
   parameter int WORD_W = 128,
   parameter int CNT_W  = 8
) (
   input  logic          clk_in,
   input  logic          rst_in,
   flit_packer_if.slave  bus
);
   localparam int BUF_W  = 2 * WORD_W;
   localparam int FILL_W = $clog2(BUF_W + 1);
   localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
   localparam logic [CNT_W-1:0]  WORD_CNT  = CNT_W'(WORD_W);

   typedef enum logic {S_RUN, S_DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BUF_W-1:0]    r_buf;
   logic [BUF_W-1:0]    w_buf_nxt;
   logic [FILL_W-1:0]   r_fill;
   logic [FILL_W-1:0]   w_fill_nxt;
   logic                r_err;

   logic                w_in_ready;
   logic                w_out_valid;
   logic [CNT_W-1:0]    w_out_bits;
   logic                w_out_last;
   logic                w_push;
   logic                w_pop;
   logic                w_cnt_ill;
   logic [FILL_W-1:0]   w_cnt_eff;
   logic [WORD_W-1:0]   w_mask;
   logic [WORD_W-1:0]   w_payload;
   logic [BUF_W-1:0]    w_shifted;
   logic [FILL_W-1:0]   w_base;

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN: begin
            if (w_push && bus.last_in) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && w_out_last) begin
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   // Output logic; everything is forced low while reset is held
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_out_bits  = '0;
      w_out_last  = 1'b0;
      if (!rst_in) begin
         case (r_state)
            S_RUN: begin
               w_in_ready  = (r_fill <= WORD_FILL);
               w_out_valid = (r_fill >= WORD_FILL);
               w_out_bits  = WORD_CNT;
            end
            S_DRAIN: begin
               w_out_valid = 1'b1;
               if (r_fill > WORD_FILL) begin
                  w_out_bits = WORD_CNT;
               end else begin
                  w_out_bits = CNT_W'(r_fill);
                  w_out_last = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_push = bus.in_valid & w_in_ready;
   assign w_pop  = w_out_valid & bus.out_ready;

   // Oversized counts are clamped to a full word and flagged
   assign w_cnt_ill = (bus.count_in > WORD_CNT);
   assign w_cnt_eff = w_cnt_ill ? WORD_FILL : FILL_W'(bus.count_in);
   assign w_mask    = (w_cnt_eff >= WORD_FILL) ? {WORD_W{1'b1}}
                                               : ((WORD_W'(1) << w_cnt_eff) - WORD_W'(1));
   assign w_payload = bus.data_in & w_mask;

   // A push is only accepted at fill <= 128, so the payload always lands inside the buffer
   assign w_shifted = w_pop ? (r_buf >> WORD_W) : r_buf;
   assign w_base    = w_pop ? (r_fill - WORD_FILL) : r_fill;

   always_comb begin
      w_buf_nxt  = w_shifted;
      w_fill_nxt = w_base;
      if (w_push) begin
         w_buf_nxt  = w_shifted | ({{WORD_W{1'b0}}, w_payload} << w_base);
         w_fill_nxt = w_base + w_cnt_eff;
      end
      if (w_pop && w_out_last) begin
         w_buf_nxt  = '0;
         w_fill_nxt = '0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_buf  <= '0;
         r_fill <= '0;
         r_err  <= 1'b0;
      end else begin
         r_buf  <= w_buf_nxt;
         r_fill <= w_fill_nxt;
         if (w_push && w_cnt_ill) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_buf[WORD_W-1:0];
   assign bus.out_bits  = w_out_bits;
   assign bus.out_last  = w_out_last;
   assign bus.err_out   = r_err;
endmodule

// File: tb/tb_flit_packer.sv
// Randomised and directed bench for flit_packer against a bit-queue stream model.
module tb_flit_packer;
   localparam int WORD_W = 128;
   localparam int CNT_W  = 8;
   localparam logic [127:0] C1   = 128'h0123456789ABCDEFFEDCBA9876543210;
   localparam logic [127:0] ONES = {128{1'b1}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flit_packer_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();
   flit_packer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int     tests = 0;
   int     fails = 0;
   bit     exp_bits[$];
   int     pkt_len[$];
   longint in_sum  = 0;
   longint out_sum = 0;

   logic         hold = 1'b0;
   logic [127:0] h_data;
   logic [7:0]   h_bits;
   logic         h_last;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_accept(input logic [127:0] d, input int c, input logic l);
      int eff;
      eff = (c > 128) ? 128 : c;
      for (int i = 0; i < eff; i++) exp_bits.push_back(d[i]);
      pkt_len[pkt_len.size()-1] += eff;
      in_sum += eff;
      if (l) pkt_len.push_back(0);
   endtask

   task automatic check_word();
      int n;
      logic [127:0] ew;
      n  = int'(bus.out_bits);
      ew = '0;
      tests++;
      if (n > 128 || n > pkt_len[0]) begin
         fails++;
         $display("FAIL word_bits: out_bits %0d, model has %0d bits pending", n, pkt_len[0]);
         if (n > pkt_len[0]) n = pkt_len[0];
         if (n > 128) n = 128;
      end
      for (int i = 0; i < n; i++) ew[i] = exp_bits.pop_front();
      pkt_len[0] -= n;
      out_sum += int'(bus.out_bits);
      chk("word_data", bus.out_data, ew);
      if (!bus.out_last) begin
         chk("word_full_bits", 128'(bus.out_bits), 128'd128);
      end else if (pkt_len.size() < 2) begin
         tests++;
         fails++;
         $display("FAIL last_flag: out_last=1 but packet still open, expected out_last=0");
      end else begin
         chk("packet_residue", 128'(pkt_len[0]), 128'd0);
         void'(pkt_len.pop_front());
      end
   endtask

   // Compare process: scoreboard plus stability under backpressure
   always @(negedge clk) begin
      if (rst) begin
         exp_bits.delete();
         pkt_len.delete();
         pkt_len.push_back(0);
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", 128'(bus.out_valid), 128'd1);
            chk("hold_data", bus.out_data, h_data);
            chk("hold_ctl", {bus.out_last, bus.out_bits}, {h_last, h_bits});
         end
         if (bus.out_valid) begin
            if (bus.out_ready) check_word();
            hold   = !bus.out_ready;
            h_data = bus.out_data;
            h_bits = bus.out_bits;
            h_last = bus.out_last;
         end else begin
            hold = 1'b0;
         end
         if (bus.in_valid && bus.in_ready)
            model_accept(bus.data_in, int'(bus.count_in), bus.last_in);
      end
   end

   task automatic send(input logic [127:0] d, input int c, input logic l, input logic rnd_rdy);
      logic acc;
      bus.in_valid = 1'b1;
      bus.data_in  = d;
      bus.count_in = CNT_W'(c);
      bus.last_in  = l;
      acc = 1'b0;
      for (int k = 0; k < 2000 && !acc; k++) begin
         if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0, expected beat accepted");
      end
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(posedge clk);
         #1;
         done = (pkt_len.size() == 1) && (pkt_len[0] == 0) && (exp_bits.size() == 0)
                && bus.in_ready && !bus.out_valid;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d bits still pending, expected 0", exp_bits.size());
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d;
      int c;
      logic l;
      bus.in_valid  = 1'b0;
      bus.data_in   = '0;
      bus.count_in  = '0;
      bus.last_in   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values while reset is held
      #12;
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_data", bus.out_data, 128'd0);
      chk("rst_out_bits", 128'(bus.out_bits), 128'd0);
      chk("rst_out_last", 128'(bus.out_last), 128'd0);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      chk("rst_err", 128'(bus.err_out), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

      // Single full-width beat
      bus.out_ready = 1'b1;
      send(C1, 128, 1'b0, 1'b0);
      chk("t1_valid", 128'(bus.out_valid), 128'd1);
      chk("t1_data", bus.out_data, C1);
      chk("t1_bits", 128'(bus.out_bits), 128'd128);
      chk("t1_last", 128'(bus.out_last), 128'd0);
      @(posedge clk);
      #1;
      chk("t1_empty", 128'(bus.out_valid), 128'd0);

      // 40 + 40 + 60 ones, last on the third beat
      send(ONES, 40, 1'b0, 1'b0);
      send(ONES, 40, 1'b0, 1'b0);
      send(ONES, 60, 1'b1, 1'b0);
      chk("t2_w0_data", bus.out_data, ONES);
      chk("t2_w0_ctl", {bus.out_valid, bus.out_last, bus.out_bits}, {1'b1, 1'b0, 8'd128});
      chk("t2_drain_in_ready", 128'(bus.in_ready), 128'd0);
      @(posedge clk);
      #1;
      chk("t2_w1_data", bus.out_data, 128'hFFF);
      chk("t2_w1_ctl", {bus.out_valid, bus.out_last, bus.out_bits}, {1'b1, 1'b1, 8'd12});
      chk("t2_drain_in_ready2", 128'(bus.in_ready), 128'd0);
      @(posedge clk);
      #1;
      chk("t2_back_to_run", 128'(bus.in_ready), 128'd1);

      // Backpressure
      bus.out_ready = 1'b0;
      send(rnd128(), 100, 1'b0, 1'b0);
      chk("t3_ready_at_100", 128'(bus.in_ready), 128'd1);
      send(rnd128(), 100, 1'b0, 1'b0);
      chk("t3_ready_at_200", 128'(bus.in_ready), 128'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("t3_stalled_ready", 128'(bus.in_ready), 128'd0);
      chk("t3_stalled_valid", 128'(bus.out_valid), 128'd1);
      bus.out_ready = 1'b1;
      send(rnd128(), 0, 1'b1, 1'b0);
      wait_idle();

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
         end
         d = rnd128();
         c = $urandom_range(0, 128);
         l = ($urandom_range(0, 15) == 0) || (i == 9999);
         send(d, c, l, 1'b1);
      end
      wait_idle();
      chk("bit_totals", 128'(out_sum), 128'(in_sum));

      // Oversized count
      d = rnd128();
      send(d, 200, 1'b0, 1'b0);
      chk("t5_err", 128'(bus.err_out), 128'd1);
      chk("t5_data", bus.out_data, d);
      send(rnd128(), 50, 1'b1, 1'b0);
      wait_idle();
      chk("t5_err_sticky", 128'(bus.err_out), 128'd1);

      // Reset in the middle of a drain
      bus.out_ready = 1'b0;
      send(rnd128(), 70, 1'b1, 1'b0);
      chk("t6_drain_ctl", {bus.out_valid, bus.out_last, bus.out_bits}, {1'b1, 1'b1, 8'd70});
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_ctl", {bus.out_valid, bus.out_last, bus.out_bits, bus.in_ready, bus.err_out}, '0);
      chk("t6_rst_data", bus.out_data, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_post_ready", {bus.in_ready, bus.out_valid}, 128'b10);
      bus.out_ready = 1'b1;
      send(C1, 128, 1'b0, 1'b0);
      chk("t6_fill_zero", bus.out_data, C1);
      send(128'd0, 0, 1'b1, 1'b0);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
